// File: rtl/nibble_mult_sched_pkg.sv
// Shared constants and state encoding for the nibble-serial multiply sequencer.
package nibble_mult_sched_pkg;

  localparam int NIB_W  = 4;
  localparam int PASS_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mult4_array.sv
// Shared 4x4 unsigned array multiplier; LAT=1 adds an output register.
module mult4_array #(
  parameter int LAT = 0
) (
  input  logic       clk,
  input  logic [3:0] m,
  input  logic [3:0] q,
  output logic [7:0] p
);

  logic [7:0] w_p;
  logic [7:0] r_p;

  // Rows of AND-gated multiplicand, each shifted by its multiplier bit weight.
  always_comb begin
    w_p = '0;
    for (int i = 0; i < 4; i++) begin
      if (q[i]) w_p = w_p + ({4'b0000, m} << i);
    end
  end

  always_ff @(posedge clk) begin
    r_p <= w_p;
  end

  assign p = (LAT == 1) ? r_p : w_p;

endmodule

// File: rtl/nibble_mult_sched.sv
// Sequences one shared 4x4 multiplier over all nibble pairs of two OPW-bit operands,
// shifting and accumulating the partial products into a 2*OPW-bit result.
module nibble_mult_sched
  import nibble_mult_sched_pkg::*;
#(
  parameter int OPW     = 8,
  parameter int MUL_LAT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPW-1:0]     in_a,
  input  logic [OPW-1:0]     in_b,
  output logic [3:0]         mul_m,
  output logic [3:0]         mul_q,
  input  logic [7:0]         mul_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*OPW-1:0]   out_prod,
  output logic               busy,
  output logic [3:0]         pass_idx
);

  localparam int NIB    = OPW / NIB_W;
  localparam int PASSES = NIB * NIB;
  localparam int PW     = 2 * OPW;
  localparam logic [PASS_W-1:0] LAST_K = PASS_W'(PASSES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PASS_W-1:0]   r_k;
  logic [OPW-1:0]      r_a;
  logic [OPW-1:0]      r_b;
  logic [PW-1:0]       r_acc;
  logic                w_accept;
  logic                w_last;
  logic                w_acc_en;
  logic [PASS_W-1:0]   w_acc_k;

  // Partial product of pass k lands at weight 4*(i+j), i = k mod NIB, j = k div NIB.
  function automatic logic [PW-1:0] shifted_pp(input logic [7:0] p, input logic [PASS_W-1:0] k);
    logic [PW-1:0] t;
    int            sh;
    t      = '0;
    t[7:0] = p;
    sh     = NIB_W * ((int'(k) % NIB) + (int'(k) / NIB));
    return t << sh;
  endfunction

  function automatic logic [3:0] nibble(input logic [OPW-1:0] v, input int idx);
    return 4'(v >> (NIB_W * idx));
  endfunction

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_last   = (r_k == LAST_K);

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    pass_idx    = '0;
    mul_m       = '0;
    mul_q       = '0;
    out_prod    = '0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        pass_idx = r_k;
        mul_m    = nibble(r_a, int'(r_k) % NIB);
        mul_q    = nibble(r_b, int'(r_k) / NIB);
        if (w_last) w_state_nxt = (MUL_LAT == 1) ? ST_DRAIN : ST_DONE;
      end
      ST_DRAIN: begin
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        out_prod  = r_acc;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)                              r_k <= '0;
    else if (w_accept)                    r_k <= '0;
    else if (r_state == ST_RUN && !w_last) r_k <= r_k + 1'b1;
  end

  // Operands are latched once so later changes on in_a/in_b cannot disturb a running op.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= in_a;
      r_b <= in_b;
    end
  end

  // With a registered multiplier the product trails its issue by a cycle, so the pass
  // index and an accumulate-enable travel one stage behind the issued k.
  generate
    if (MUL_LAT == 1) begin : g_pipe
      logic              r_vld_p1;
      logic [PASS_W-1:0] r_k_p1;

      always_ff @(posedge clk) begin
        if (rst) r_vld_p1 <= 1'b0;
        else     r_vld_p1 <= (r_state == ST_RUN);
      end

      always_ff @(posedge clk) begin
        r_k_p1 <= r_k;
      end

      assign w_acc_en = r_vld_p1;
      assign w_acc_k  = r_k_p1;
    end else begin : g_comb
      assign w_acc_en = (r_state == ST_RUN);
      assign w_acc_k  = r_k;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)           r_acc <= '0;
    else if (w_accept) r_acc <= '0;
    else if (w_acc_en) r_acc <= r_acc + shifted_pp(mul_p, w_acc_k);
  end

endmodule

// File: tb/tb_nibble_mult_sched.sv
// Bench for nibble_mult_sched: OPW=8 combinational, OPW=8 registered and OPW=4 variants,
// each beside its own mult4_array, compared against a plain a*b reference with latency rules.
module tb_nibble_mult_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks;
  int   failures;

  logic       v8, rdy8, ov8, or8, busy8;
  logic [7:0] a8, b8, p8;
  logic [3:0] m8, q8, pidx8;
  logic [15:0] prod8;

  logic       vL, rdyL, ovL, orL, busyL;
  logic [7:0] aL, bL, pL;
  logic [3:0] mL, qL, pidxL;
  logic [15:0] prodL;

  logic       v4, rdy4, ov4, or4, busy4;
  logic [3:0] a4, b4, m4, q4, pidx4;
  logic [7:0] p4, prod4;

  mult4_array #(.LAT(0)) u_mul8 (.clk(clk), .m(m8), .q(q8), .p(p8));
  nibble_mult_sched #(.OPW(8), .MUL_LAT(0)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_a(a8), .in_b(b8),
    .mul_m(m8), .mul_q(q8), .mul_p(p8), .out_valid(ov8), .out_ready(or8),
    .out_prod(prod8), .busy(busy8), .pass_idx(pidx8));

  mult4_array #(.LAT(1)) u_mulL (.clk(clk), .m(mL), .q(qL), .p(pL));
  nibble_mult_sched #(.OPW(8), .MUL_LAT(1)) u_dutL (
    .clk(clk), .rst(rst), .in_valid(vL), .in_ready(rdyL), .in_a(aL), .in_b(bL),
    .mul_m(mL), .mul_q(qL), .mul_p(pL), .out_valid(ovL), .out_ready(orL),
    .out_prod(prodL), .busy(busyL), .pass_idx(pidxL));

  mult4_array #(.LAT(0)) u_mul4 (.clk(clk), .m(m4), .q(q4), .p(p4));
  nibble_mult_sched #(.OPW(4), .MUL_LAT(0)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_a(a4), .in_b(b4),
    .mul_m(m4), .mul_q(q4), .mul_p(p4), .out_valid(ov4), .out_ready(or4),
    .out_prod(prod4), .busy(busy4), .pass_idx(pidx4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v8 = 0; a8 = 0; b8 = 0; or8 = 0;
    vL = 0; aL = 0; bL = 0; orL = 0;
    v4 = 0; a4 = 0; b4 = 0; or4 = 0;
    step(); step();
    rst = 1'b0;
    checks++;
    if ({rdy8, ov8, busy8, pidx8, m8, q8, prod8} !== {1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 16'd0}) begin
      failures++;
      $display("FAIL reset_opw8 got=%h exp=%h", {rdy8, ov8, busy8, pidx8, m8, q8, prod8},
               {1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 16'd0});
    end
    checks++;
    if ({rdyL, ovL, busyL, pidxL, mL, qL, prodL} !== {1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 16'd0}) begin
      failures++;
      $display("FAIL reset_lat1 got=%h", {rdyL, ovL, busyL, pidxL, mL, qL, prodL});
    end
    checks++;
    if ({rdy4, ov4, busy4, pidx4, m4, q4, prod4} !== {1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 8'd0}) begin
      failures++;
      $display("FAIL reset_opw4 got=%h", {rdy4, ov4, busy4, pidx4, m4, q4, prod4});
    end
  endtask

  task automatic test_full_ones();
    logic [7:0] ea, eb;
    logic [3:0] em, eq;
    ea = 8'hFF; eb = 8'hFF;
    a8 = ea; b8 = eb; v8 = 1'b1;
    step();
    v8 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      em = 4'(ea >> (4 * (c % 2)));
      eq = 4'(eb >> (4 * (c / 2)));
      checks++;
      if ({pidx8, m8, q8, rdy8, busy8, ov8} !== {4'(c), em, eq, 1'b0, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL ff_pass%0d got pidx/m/q/rdy/busy/ov=%h exp=%h", c,
                 {pidx8, m8, q8, rdy8, busy8, ov8}, {4'(c), em, eq, 1'b0, 1'b1, 1'b0});
      end
      step();
    end
    checks++;
    if ({ov8, prod8} !== {1'b1, 16'hFE01}) begin
      failures++;
      $display("FAIL ff_result got ov=%0b prod=%h exp ov=1 prod=fe01", ov8, prod8);
    end
    or8 = 1'b1;
    step();
    or8 = 1'b0;
    checks++;
    if ({ov8, rdy8, busy8} !== 3'b010) begin
      failures++;
      $display("FAIL ff_retire got ov/rdy/busy=%b exp=010", {ov8, rdy8, busy8});
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [7:0] ea [2];
    logic [7:0] eb [2];
    ea[0] = 8'h00; eb[0] = 8'hA5;
    ea[1] = 8'h12; eb[1] = 8'h34;
    for (int n = 0; n < 2; n++) begin
      a8 = ea[n]; b8 = eb[n]; v8 = 1'b1;
      step();
      v8 = 1'b0;
      a8 = 8'hEE; b8 = 8'hDD;
      cyc = 0;
      while (!ov8 && cyc < 40) begin
        checks++;
        if (rdy8 !== 1'b0) begin
          failures++;
          $display("FAIL b2b_ready_while_busy op%0d got=%0b exp=0", n, rdy8);
        end
        step();
        cyc++;
      end
      checks++;
      if (!ov8 || cyc != 4 || prod8 !== 16'(int'(ea[n]) * int'(eb[n]))) begin
        failures++;
        $display("FAIL b2b_result op%0d got ov=%0b lat=%0d prod=%h exp lat=4 prod=%h",
                 n, ov8, cyc, prod8, 16'(int'(ea[n]) * int'(eb[n])));
      end
      if (n == 0) begin
        or8 = 1'b1;
        step();
        or8 = 1'b0;
      end
    end
  endtask

  task automatic test_hold();
    a8 = 8'h55; b8 = 8'h66; v8 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({ov8, prod8, rdy8} !== {1'b1, 16'h03A8, 1'b0}) begin
        failures++;
        $display("FAIL hold_cycle%0d got ov/prod/rdy=%h exp=%h", c, {ov8, prod8, rdy8},
                 {1'b1, 16'h03A8, 1'b0});
      end
      step();
    end
    or8 = 1'b1;
    step();
    or8 = 1'b0;
    v8  = 1'b0;
    checks++;
    if ({ov8, rdy8, busy8, pidx8} !== {1'b0, 1'b1, 1'b0, 4'd0}) begin
      failures++;
      $display("FAIL hold_retire_with_in_valid got ov/rdy/busy/pidx=%h", {ov8, rdy8, busy8, pidx8});
    end
    or8 = 1'b1;
    step();
    or8 = 1'b0;
    checks++;
    if ({ov8, rdy8, busy8} !== 3'b010) begin
      failures++;
      $display("FAIL idle_out_ready got ov/rdy/busy=%b exp=010", {ov8, rdy8, busy8});
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    a8 = 8'hC3; b8 = 8'h7E; v8 = 1'b1;
    step();
    v8 = 1'b0;
    step(); step();
    checks++;
    if (pidx8 !== 4'd2) begin
      failures++;
      $display("FAIL midrst_pass got=%0d exp=2", pidx8);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({rdy8, ov8, busy8, pidx8, m8, q8, prod8} !== {1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 16'd0}) begin
      failures++;
      $display("FAIL midrst_state got=%h", {rdy8, ov8, busy8, pidx8, m8, q8, prod8});
    end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if ({ov8, busy8} !== 2'b00) begin
        failures++;
        $display("FAIL midrst_quiet cycle%0d got ov/busy=%b exp=00", c, {ov8, busy8});
      end
    end
    a8 = 8'h03; b8 = 8'h05; v8 = 1'b1;
    step();
    v8 = 1'b0;
    cyc = 0;
    while (!ov8 && cyc < 40) begin step(); cyc++; end
    checks++;
    if (!ov8 || cyc != 4 || prod8 !== 16'h000F) begin
      failures++;
      $display("FAIL midrst_next_op got ov=%0b lat=%0d prod=%h exp prod=000f", ov8, cyc, prod8);
    end
    or8 = 1'b1;
    step();
    or8 = 1'b0;
  endtask

  task automatic test_random8(input int n_ops);
    int cyc;
    int stall;
    logic [7:0] ea, eb;
    logic [15:0] expv;
    for (int n = 0; n < n_ops; n++) begin
      ea = 8'($urandom); eb = 8'($urandom);
      a8 = ea; b8 = eb; v8 = 1'b1;
      step();
      v8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom);
      expv = 16'(int'(ea) * int'(eb));
      cyc = 0;
      while (!ov8 && cyc < 40) begin step(); cyc++; end
      checks++;
      if (!ov8 || cyc != 4 || prod8 !== expv) begin
        failures++;
        $display("FAIL rand8 op%0d a=%h b=%h got ov=%0b lat=%0d prod=%h exp lat=4 prod=%h",
                 n, ea, eb, ov8, cyc, prod8, expv);
      end
      stall = $urandom_range(0, 2);
      repeat (stall) step();
      or8 = 1'b1;
      step();
      or8 = 1'b0;
    end
  endtask

  task automatic test_lat1(input int n_ops);
    int cyc;
    logic [7:0] ea, eb;
    logic [15:0] expv;
    for (int n = 0; n <= n_ops; n++) begin
      ea = (n == 0) ? 8'hFF : 8'($urandom);
      eb = (n == 0) ? 8'h01 : 8'($urandom);
      aL = ea; bL = eb; vL = 1'b1;
      step();
      vL = 1'b0;
      aL = 8'($urandom); bL = 8'($urandom);
      expv = 16'(int'(ea) * int'(eb));
      cyc = 0;
      while (!ovL && cyc < 40) begin step(); cyc++; end
      checks++;
      if (!ovL || cyc != 5 || prodL !== expv) begin
        failures++;
        $display("FAIL lat1 op%0d a=%h b=%h got ov=%0b lat=%0d prod=%h exp lat=5 prod=%h",
                 n, ea, eb, ovL, cyc, prodL, expv);
      end
      repeat ($urandom_range(0, 2)) step();
      orL = 1'b1;
      step();
      orL = 1'b0;
    end
  endtask

  task automatic test_opw4(input int n_ops);
    int cyc;
    logic [3:0] ea, eb;
    logic [7:0] expv;
    for (int n = 0; n <= n_ops; n++) begin
      ea = (n == 0) ? 4'hF : 4'($urandom);
      eb = (n == 0) ? 4'hD : 4'($urandom);
      a4 = ea; b4 = eb; v4 = 1'b1;
      step();
      v4 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom);
      expv = 8'(int'(ea) * int'(eb));
      cyc = 0;
      while (!ov4 && cyc < 20) begin step(); cyc++; end
      checks++;
      if (!ov4 || cyc != 1 || prod4 !== expv) begin
        failures++;
        $display("FAIL opw4 op%0d a=%h b=%h got ov=%0b lat=%0d prod=%h exp lat=1 prod=%h",
                 n, ea, eb, ov4, cyc, prod4, expv);
      end
      repeat ($urandom_range(0, 1)) step();
      or4 = 1'b1;
      step();
      or4 = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_full_ones();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_random8(200);
    test_lat1(200);
    test_opw4(1000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
